// File: rtl/prio_arbiter_if.sv
// Requester-side bundle for prio_arbiter: request/mode/release in, registered grant status out.
// master = requester/controller side, slave = arbiter side.
interface prio_arbiter_if #(
    parameter int N = 4,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req_in;
    logic         mode_in;
    logic         done_in;
    logic [N-1:0] grant_out;
    logic [W-1:0] grant_idx_out;
    logic         valid_out;
    logic         busy_out;

    modport master (
        output req_in, mode_in, done_in,
        input  grant_out, grant_idx_out, valid_out, busy_out
    );

    modport slave (
        input  req_in, mode_in, done_in,
        output grant_out, grant_idx_out, valid_out, busy_out
    );
endinterface

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter (fixed-highest or round-robin); 1 cycle request-to-grant, 1 cycle release.
// No backpressure: a grant is held until done_in or withdrawal, then one IDLE cycle before the next.
module prio_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    prio_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_grant;
    logic [W-1:0] r_idx;
    logic         r_valid;
    logic         r_busy;
    logic [W-1:0] r_last;

    logic [W-1:0] w_fix_idx;
    logic [W-1:0] w_rr_idx;
    logic [W-1:0] w_win;
    logic         w_release;

    always_comb begin
        w_fix_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.req_in[k]) w_fix_idx = W'(k);
        end
        // Scan offsets far-to-near so the nearest requester after r_last is assigned last.
        w_rr_idx = '0;
        for (int d = N; d >= 1; d--) begin
            if (bus.req_in[(int'(r_last) + d) % N]) w_rr_idx = W'((int'(r_last) + d) % N);
        end
        w_win     = bus.mode_in ? w_rr_idx : w_fix_idx;
        w_release = bus.done_in || !bus.req_in[r_idx];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= W'(N - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req_in) begin
                        r_state <= GRANT;
                        r_grant <= N'(1) << w_win;
                        r_idx   <= w_win;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= w_win;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant_out     = r_grant;
    assign bus.grant_idx_out = r_idx;
    assign bus.valid_out     = r_valid;
    assign bus.busy_out      = r_busy;

endmodule
